// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES state collector that registers InvShiftRows of each 16-byte block.
// Optional macro INV_SHIFT_ROWS_DIR_EN adds a dir port selecting forward ShiftRows (dir = 0).
module inv_shift_rows_stream #(
  parameter int Nb = 128,
  parameter int Bw = 8
) (
  input  logic          Clk,
  input  logic          Rst,
`ifdef INV_SHIFT_ROWS_DIR_EN
  input  logic          dir,
`endif
  input  logic [Bw-1:0] in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [Nb-1:0] out_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    byte_cnt
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t        state_r;
  logic [Bw-1:0] buf_r [0:15];
  logic [3:0]    byte_cnt_r;
  logic [Nb-1:0] out_state_r;
  logic          out_valid_r;
  logic [Nb-1:0] block_s;
  logic          inv_sel_s;

  // Row r of column c comes from column (c - r) mod 4 when inverting, (c + r) mod 4 otherwise.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] res;
    int           src;
    res = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) begin
          src = 4 * ((c - r + 4) % 4) + r;
        end else begin
          src = 4 * ((c + r) % 4) + r;
        end
        res[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * src -: 8];
      end
    end
    return res;
  endfunction

`ifdef INV_SHIFT_ROWS_DIR_EN
  assign inv_sel_s = dir;
`else
  assign inv_sel_s = 1'b1;
`endif

  // Full block as seen on the edge that accepts the last byte: 15 stored bytes plus in_byte.
  always_comb begin
    block_s = '0;
    for (int i = 0; i < 15; i++) begin
      block_s[Nb - 1 - 8 * i -: 8] = buf_r[i];
    end
    block_s[Bw-1:0] = in_byte;
  end

  // Collect/hold state machine with registered result and handshake flags.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r     <= COLLECT;
      byte_cnt_r  <= 4'd0;
      out_state_r <= '0;
      out_valid_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      case (state_r)
        COLLECT: begin
          if (in_valid) begin
            buf_r[byte_cnt_r] <= in_byte;
            if (byte_cnt_r == 4'd15) begin
              out_state_r <= shift_rows(block_s, inv_sel_s);
              out_valid_r <= 1'b1;
              byte_cnt_r  <= 4'd0;
              state_r     <= HOLD;
            end else begin
              byte_cnt_r  <= byte_cnt_r + 4'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= COLLECT;
          end
        end
        default: begin
          state_r     <= COLLECT;
          byte_cnt_r  <= 4'd0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == COLLECT);
  assign out_state = out_state_r;
  assign out_valid = out_valid_r;
  assign byte_cnt  = byte_cnt_r;

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// Directed and randomized bench for inv_shift_rows_stream against a grid-based ShiftRows model.
module tb_inv_shift_rows_stream;

  logic         Clk;
  logic         Rst;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   byte_cnt;
  logic         dir;

  int vectors;
  int miscompares;
  int cyc;

  inv_shift_rows_stream dut (
    .Clk       (Clk),
    .Rst       (Rst),
`ifdef INV_SHIFT_ROWS_DIR_EN
    .dir       (dir),
`endif
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_state (out_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .byte_cnt  (byte_cnt)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Reference: lay the state out as a 4x4 grid and rotate each row by its index.
  function automatic logic [127:0] model(input logic [127:0] vec, input bit inv);
    logic [7:0]   g [4][4];
    logic [127:0] res;
    int           r;
    int           c;
    int           src;
    for (int i = 0; i < 16; i++) g[i % 4][i / 4] = vec[127 - 8 * i -: 8];
    res = 128'd0;
    for (int i = 0; i < 16; i++) begin
      r = i % 4;
      c = i / 4;
      src = inv ? (c - r + 4) % 4 : (c + r) % 4;
      res[127 - 8 * i -: 8] = g[r][src];
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present the first n bytes of vec, optionally with random idle gaps; each wait is bounded.
  task automatic send(input logic [127:0] vec, input int n, input int max_gap);
    int  gap;
    int  waited;
    bit  acc;
    bit  done;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        @(posedge Clk); #1;
      end
      in_valid = 1'b1;
      in_byte  = vec[127 - 8 * i -: 8];
      waited   = 0;
      done     = 1'b0;
      while (!done) begin
        acc = in_ready;
        @(posedge Clk); #1;
        if (acc) begin
          done = 1'b1;
        end else begin
          waited++;
          if (waited > 40) begin
            check("accept_timeout", {127'd0, in_ready}, 128'd1);
            done = 1'b1;
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge Clk); #1;
    check("hs_out_valid", {127'd0, out_valid}, 128'd0);
    check("hs_in_ready", {127'd0, in_ready}, 128'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] v;
    logic [127:0] exp;
    int           t1;
    int           t2;
    bit           d;

    vectors = 0; miscompares = 0; cyc = 0;
    Clk = 1'b0; Rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b0; dir = 1'b1;

    // Reset state, with bytes offered during reset that must not be stored
    #12;
    check("rst_in_ready", {127'd0, in_ready}, 128'd1);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_byte_cnt", {124'd0, byte_cnt}, 128'd0);
    check("rst_out_state", out_state, 128'd0);
    in_valid = 1'b1; in_byte = 8'hA5;
    @(posedge Clk); #1;
    check("rst_no_store", {124'd0, byte_cnt}, 128'd0);
    Rst = 1'b0; in_valid = 1'b0;
    #1;

    // Test 1: continuous stream, latency of one edge after the 16th byte
    send(128'h6353e08c0960e104cd70b751bacad0e7, 15, 0);
    check("t1_cnt15", {124'd0, byte_cnt}, 128'd15);
    check("t1_not_yet", {127'd0, out_valid}, 128'd0);
    send(128'h6353e08c0960e104cd70b751bacad0e7 << 120, 1, 0);
    check("t1_valid", {127'd0, out_valid}, 128'd1);
    check("t1_state", out_state, 128'h63cab7040953d051cd60e0e7ba70e18c);
    check("t1_cnt0", {124'd0, byte_cnt}, 128'd0);
    check("t1_in_ready", {127'd0, in_ready}, 128'd0);
    handshake();

    // Test 2: random gaps, 5-cycle stall with stray in_valid pulses
    send(128'ha7be1a6997ad739bd8c9ca451f618b61, 16, 3);
    exp = 128'ha761ca9b97be8b45d8ad1a611fc97369;
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0) ? 1'b1 : 1'($urandom);
      in_byte  = 8'($urandom);
      @(posedge Clk); #1;
      check("t2_stall_state", out_state, exp);
      check("t2_stall_valid", {127'd0, out_valid}, 128'd1);
      check("t2_stall_ready", {127'd0, in_ready}, 128'd0);
      check("t2_stall_cnt", {124'd0, byte_cnt}, 128'd0);
    end
    in_valid = 1'b1;
    handshake();
    in_valid = 1'b0;
    check("t2_ignored", {124'd0, byte_cnt}, 128'd0);

    // Test 3: back-to-back blocks with out_ready held high
    out_ready = 1'b1;
    send(128'h3bd92268fc74fb735767cbe0c0590e2d, 16, 0);
    t1 = cyc;
    check("t3_a_valid", {127'd0, out_valid}, 128'd1);
    check("t3_a_state", out_state, 128'h3b59cb73fcd90ee05774222dc067fb68);
    send(128'h2d6d7ef03f33e334093602dd5bfb12c7, 16, 0);
    t2 = cyc;
    check("t3_b_valid", {127'd0, out_valid}, 128'd1);
    check("t3_b_state", out_state, 128'h2dfb02343f6d12dd09337ec75b36e3f0);
    check("t3_spacing", 128'(t2 - t1), 128'd17);
    handshake();

    // Test 4: reset after 9 bytes, then a clean block
    send(128'hdeadbeef0123456789abcdeffedcba98, 9, 0);
    check("t4_cnt9", {124'd0, byte_cnt}, 128'd9);
    Rst = 1'b1; in_valid = 1'b1; in_byte = 8'h5A;
    #2;
    check("t4_rst_cnt", {124'd0, byte_cnt}, 128'd0);
    check("t4_rst_ready", {127'd0, in_ready}, 128'd1);
    @(posedge Clk); #1;
    Rst = 1'b0; in_valid = 1'b0;
    #1;
    send(128'he8dab6901477d4653ff7f5e2e747dd4f, 16, 1);
    check("t4_state", out_state, 128'he847f56514dadde23f77b64fe7f7d490);
    check("t4_valid", {127'd0, out_valid}, 128'd1);

    // Reset while holding a result drops it
    @(posedge Clk); #1;
    Rst = 1'b1;
    #2;
    check("t4_hold_rst_valid", {127'd0, out_valid}, 128'd0);
    check("t4_hold_rst_state", out_state, 128'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;

`ifdef INV_SHIFT_ROWS_DIR_EN
    // Test 5: forward ShiftRows then inverse round trip
    dir = 1'b0;
    send(128'h7a9f102789d5f50b2beffd9f3dca4ea7, 16, 0);
    check("t5_fwd", out_state, 128'h7ad5fda789ef4e272bca100b3d9ff59f);
    handshake();
    dir = 1'b1;
    send(128'h7ad5fda789ef4e272bca100b3d9ff59f, 16, 0);
    check("t5_inv", out_state, 128'h7a9f102789d5f50b2beffd9f3dca4ea7);
    handshake();
`endif

    // Randomized blocks against the model
    for (int b = 0; b < 8; b++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      d = 1'b1;
`ifdef INV_SHIFT_ROWS_DIR_EN
      d = 1'($urandom);
      dir = d;
`endif
      send(v, 16, 2);
      exp = model(v, d);
      check("rnd_valid", {127'd0, out_valid}, 128'd1);
      check("rnd_state", out_state, exp);
      repeat ($urandom_range(3, 0)) begin
        @(posedge Clk); #1;
        check("rnd_hold", out_state, exp);
      end
      handshake();
    end
    dir = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stream.md
Name: inv_shift_rows_stream

Overview:
- Decryption-side companion to the combinational AES ShiftRows stage.
- Collects a 128-bit AES state one byte at a time over a valid/ready handshake and applies InvShiftRows.
- Presents the registered 128-bit result on a valid/ready output port.
- Sits between the byte-serial ciphertext/round-key path and the inverse-round datapath (InvSubBytes, AddRoundKey).

Parameters:
- Nb, 128, state width in bits; only 128 supported.
- Bw, 8, byte width in bits; only 8 supported.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- in_byte  input  Bw  state byte, sent in AES column-major order (byte 0 first).
- in_valid  input  1  in_byte valid.
- in_ready  output  1  block can accept a byte.
- out_state  output  Nb  InvShiftRows result; byte i lives at out_state[Nb-1-8i -: 8].
- out_valid  output  1  out_state valid.
- out_ready  input  1  downstream accepts out_state.
- byte_cnt  output  4  number of bytes collected so far in the current block.

Behaviour:
- Byte indexing: byte i = 4*c + r (row r, column c, 0..3). Byte 0 is stored at bits [127:120].
- InvShiftRows: out[r][c] = in[r][(c - r) mod 4]. Row 0 unchanged; row r rotates right by r.
- FSM states: COLLECT (reset state) and HOLD.
- COLLECT:
  - in_ready = 1, out_valid = 0.
  - On accept (in_valid & in_ready): write in_byte to buffer slot byte_cnt, then byte_cnt += 1.
  - On accept with byte_cnt == 15: register out_state = InvShiftRows(buffer including this byte), set out_valid = 1, byte_cnt wraps to 0, move to HOLD.
  - Latency: out_valid rises on the first edge after the 16th byte is accepted.
- HOLD:
  - in_ready = 0; in_valid is ignored.
  - out_state and out_valid stay stable until handshake.
  - On out_valid & out_ready: out_valid = 0, move to COLLECT.
  - The next block's first byte can be accepted no earlier than the cycle after the output handshake, so minimum throughput is 1 block per 17 cycles.
- in_valid low in COLLECT: no state change; gaps between bytes are allowed.
- Reset values (asynchronous, while Rst = 1 and after release): state = COLLECT, byte_cnt = 0, buffer = 0, out_state = 0, out_valid = 0, in_ready = 1. Bytes presented while Rst = 1 are not stored.
- Reset mid-block or in HOLD: partial bytes and any pending output are discarded; the block returns to reset values.
- out_valid never depends combinationally on out_ready. in_ready is decoded from the state register only.

Optional Feature:
- Macro: INV_SHIFT_ROWS_DIR_EN.
- Defined:
  - Adds input port dir (1 bit), sampled with the 16th accepted byte.
  - dir = 1: InvShiftRows.
  - dir = 0: forward ShiftRows, out[r][c] = in[r][(c + r) mod 4].
  - Lets one instance serve both the cipher and the inverse-cipher paths.
- Undefined: no dir port; InvShiftRows only.

Test Plan:
- Reset, then stream bytes of 6353e08c0960e104cd70b751bacad0e7 with in_valid held high -> out_valid = 1 on the edge after the 16th byte; out_state = 63cab7040953d051cd60e0e7ba70e18c; byte_cnt = 0.
- Stream a7be1a6997ad739bd8c9ca451f618b61 with random in_valid gaps, out_ready held low 5 cycles -> out_state = a761ca9b97be8b45d8ad1a611fc97369, stable through the stall; in_ready = 0 during HOLD; extra in_valid pulses are ignored.
- Back-to-back blocks 3bd92268fc74fb735767cbe0c0590e2d then 2d6d7ef03f33e334093602dd5bfb12c7 with out_ready = 1 -> outputs 3b59cb73fcd90ee05774222dc067fb68 then 2dfb02343f6d12dd09337ec75b36e3f0; 17-cycle spacing.
- Assert Rst after 9 bytes, release, then stream e8dab6901477d4653ff7f5e2e747dd4f -> out_state = e847f56514dadde23f77b64fe7f7d490; no residue from the partial block.
- With INV_SHIFT_ROWS_DIR_EN defined and dir = 0, stream 7a9f102789d5f50b2beffd9f3dca4ea7 -> out_state = 7ad5fda789ef4e272bca100b3d9ff59f. With dir = 1, stream that result back -> out_state = 7a9f102789d5f50b2beffd9f3dca4ea7.
